// File: rtl/layered_pixel_pipe.sv
// layered_pixel_pipe: three-stage pixel compositor sitting between the VGA
// controller and the VGA port. Layers, front to back: debug-sequence rows,
// NUM_SPRITES colour-keyed sprites (lowest index in front), a map window and
// a flat background. Sprite positions are shadowed once per frame, and
// sprite-0 overlaps with every other sprite are reported once per frame.
module layered_pixel_pipe #(
  parameter int                     PIXEL_WIDTH  = 12,
  parameter int                     SCREEN_WIDTH = 10,
  parameter int                     SEQ_NUM      = 16,
  parameter int                     SEQ_DIGITS   = 4,
  parameter int                     FONT_WIDTH   = 8,
  parameter int                     SEQ_INTERVAL = 5,
  parameter int                     NUM_SPRITES  = 4,
  parameter int                     SPR_WIDTH_X  = 32,
  parameter int                     SPR_WIDTH_Y  = 32,
  parameter int                     MAP_X_OFFSET = 270,
  parameter int                     MAP_Y_OFFSET = 50,
  parameter int                     MAP_WIDTH_X  = 100,
  parameter int                     MAP_WIDTH_Y  = 100,
  parameter logic [PIXEL_WIDTH-1:0] KEY_COLOR    = 12'hF0F,
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR     = 12'hFFF
) (
  input  logic                                                     sys_clk,
  input  logic                                                     sys_rst,
  input  logic                                                     video_on,
  input  logic                                                     hsync_in,
  input  logic                                                     vsync_in,
  input  logic [SCREEN_WIDTH-1:0]                                  x,
  input  logic [SCREEN_WIDTH-1:0]                                  y,
  input  logic                                                     frame_tick,
  input  logic [NUM_SPRITES*SCREEN_WIDTH-1:0]                      spr_x_in,
  input  logic [NUM_SPRITES*SCREEN_WIDTH-1:0]                      spr_y_in,
  input  logic [NUM_SPRITES-1:0]                                   spr_en_in,
  input  logic                                                     debug_en,
  input  logic [SEQ_NUM*SEQ_DIGITS*FONT_WIDTH*FONT_WIDTH*PIXEL_WIDTH-1:0] debug_seq,
  output logic [NUM_SPRITES*$clog2(SPR_WIDTH_X)-1:0]               spr_addr_x,
  output logic [NUM_SPRITES*$clog2(SPR_WIDTH_Y)-1:0]               spr_addr_y,
  input  logic [NUM_SPRITES*PIXEL_WIDTH-1:0]                       spr_rgb,
  output logic [SCREEN_WIDTH-1:0]                                  map_addr_x,
  output logic [SCREEN_WIDTH-1:0]                                  map_addr_y,
  input  logic [PIXEL_WIDTH-1:0]                                   map_rgb,
  output logic [PIXEL_WIDTH-1:0]                                   rgb,
  output logic                                                     video_on_out,
  output logic                                                     hsync_out,
  output logic                                                     vsync_out,
  output logic [NUM_SPRITES-1:0]                                   collide
);

  localparam int AXW       = $clog2(SPR_WIDTH_X);
  localparam int AYW       = $clog2(SPR_WIDTH_Y);
  // One extra bit so that "pixel left of / above the origin" shows up as a
  // huge unsigned difference instead of wrapping into the sprite.
  localparam int CW        = SCREEN_WIDTH + 1;
  localparam int ROW_PIX   = SEQ_DIGITS * FONT_WIDTH;
  localparam int UNIT      = ROW_PIX * FONT_WIDTH * PIXEL_WIDTH;
  localparam int SEQ_BITS  = SEQ_NUM * UNIT;
  localparam int ROW_PITCH = FONT_WIDTH + SEQ_INTERVAL;
  localparam int KW        = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1;
  localparam int RW        = (FONT_WIDTH > 1) ? $clog2(FONT_WIDTH) : 1;
  localparam int CLW       = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam int IW        = $clog2(SEQ_BITS);

  localparam logic [CW-1:0] SPR_W_X = CW'(SPR_WIDTH_X);
  localparam logic [CW-1:0] SPR_W_Y = CW'(SPR_WIDTH_Y);
  localparam logic [CW-1:0] MAP_X0  = CW'(MAP_X_OFFSET);
  localparam logic [CW-1:0] MAP_Y0  = CW'(MAP_Y_OFFSET);
  localparam logic [CW-1:0] MAP_W_X = CW'(MAP_WIDTH_X);
  localparam logic [CW-1:0] MAP_W_Y = CW'(MAP_WIDTH_Y);
  localparam logic [CW-1:0] FONT_W  = CW'(FONT_WIDTH);
  localparam logic [CW-1:0] ROW_W   = CW'(ROW_PIX);

  // Per-frame sprite shadows
  logic [NUM_SPRITES*SCREEN_WIDTH-1:0] spr_x_q, spr_y_q;
  logic [NUM_SPRITES-1:0]              spr_en_q;

  // Stage 1
  logic [NUM_SPRITES-1:0]     s1_spr_hit_d, s1_spr_hit_q;
  logic [NUM_SPRITES*AXW-1:0] spr_ax_d, spr_ax_q;
  logic [NUM_SPRITES*AYW-1:0] spr_ay_d, spr_ay_q;
  logic                       s1_map_hit_d, s1_map_hit_q;
  logic [CW-1:0]              map_dx, map_dy;
  logic [SCREEN_WIDTH-1:0]    map_ax_q, map_ay_q;
  logic                       s1_dbg_hit_d, s1_dbg_hit_q;
  logic [KW-1:0]              s1_dbg_row_d, s1_dbg_row_q;
  logic [RW-1:0]              s1_dbg_r_d, s1_dbg_r_q;
  logic [CLW-1:0]             s1_dbg_c_d, s1_dbg_c_q;
  logic                       s1_dbg_en_q, s1_vo_q, s1_hs_q, s1_vs_q;

  // Stage 2
  logic [IW-1:0]              dbg_idx;
  logic [PIXEL_WIDTH-1:0]     dbg_pix_d, dbg_pix_q;
  logic [NUM_SPRITES-1:0]     s2_spr_hit_q;
  logic                       s2_map_hit_q, s2_dbg_hit_q, s2_dbg_en_q;
  logic                       s2_vo_q, s2_hs_q, s2_vs_q;

  // Stage 3
  logic [NUM_SPRITES-1:0]     opaque;
  logic [NUM_SPRITES-1:0]     hits;
  logic                       spr_found;
  logic [PIXEL_WIDTH-1:0]     spr_pix;
  logic [PIXEL_WIDTH-1:0]     rgb_d, rgb_q;
  logic                       vo_q, hs_q, vs_q;
  logic [NUM_SPRITES-1:0]     acc_d, acc_q;
  logic [NUM_SPRITES-1:0]     collide_d, collide_q;

  logic [CW-1:0]              x_e, y_e;
  assign x_e = {1'b0, x};
  assign y_e = {1'b0, y};

  // Shadow sprite state: reload only on the frame tick so a frame never tears.
  always_ff @(posedge sys_clk) begin
    // NOTE: clocked state uses <= so every register sees pre-edge values; combinational blocks use =.
    // NOTE: sys_rst is synchronous -- it is just another input sampled on the edge, and it beats frame_tick.
    if (sys_rst) begin
      spr_x_q  <= '0;
      spr_y_q  <= '0;
      spr_en_q <= '0;
    end else if (frame_tick) begin
      spr_x_q  <= spr_x_in;
      spr_y_q  <= spr_y_in;
      spr_en_q <= spr_en_in;
    end
  end

  // Stage 1 sprite hit tests and sprite-local ROM addresses.
  always_comb begin
    logic [CW-1:0] dx, dy;
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    s1_spr_hit_d = '0;
    spr_ax_d     = '0;
    spr_ay_d     = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx = x_e - {1'b0, spr_x_q[i*SCREEN_WIDTH +: SCREEN_WIDTH]};
      dy = y_e - {1'b0, spr_y_q[i*SCREEN_WIDTH +: SCREEN_WIDTH]};
      s1_spr_hit_d[i]          = spr_en_q[i] && (dx < SPR_W_X) && (dy < SPR_W_Y);
      spr_ax_d[i*AXW +: AXW]   = dx[AXW-1:0];
      spr_ay_d[i*AYW +: AYW]   = dy[AYW-1:0];
    end
  end

  assign map_dx       = x_e - MAP_X0;
  assign map_dy       = y_e - MAP_Y0;
  assign s1_map_hit_d = (map_dx < MAP_W_X) && (map_dy < MAP_W_Y);

  // Stage 1 debug-row search; rows never overlap so at most one matches.
  always_comb begin
    logic [CW-1:0] ddy;
    s1_dbg_hit_d = 1'b0;
    s1_dbg_row_d = '0;
    s1_dbg_r_d   = '0;
    s1_dbg_c_d   = x[CLW-1:0];
    for (int k = 0; k < SEQ_NUM; k++) begin
      ddy = y_e - CW'(k * ROW_PITCH);
      if ((x_e < ROW_W) && (ddy < FONT_W)) begin
        s1_dbg_hit_d = 1'b1;
        s1_dbg_row_d = KW'(k);
        s1_dbg_r_d   = ddy[RW-1:0];
      end
    end
  end

  // Stage 1 registers: flags, ROM addresses, debug coordinates, sync delay.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_spr_hit_q <= '0;
      spr_ax_q     <= '0;
      spr_ay_q     <= '0;
      s1_map_hit_q <= 1'b0;
      map_ax_q     <= '0;
      map_ay_q     <= '0;
      s1_dbg_hit_q <= 1'b0;
      s1_dbg_row_q <= '0;
      s1_dbg_r_q   <= '0;
      s1_dbg_c_q   <= '0;
      s1_dbg_en_q  <= 1'b0;
      s1_vo_q      <= 1'b0;
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
    end else begin
      s1_spr_hit_q <= s1_spr_hit_d;
      spr_ax_q     <= spr_ax_d;
      spr_ay_q     <= spr_ay_d;
      s1_map_hit_q <= s1_map_hit_d;
      map_ax_q     <= map_dx[SCREEN_WIDTH-1:0];
      map_ay_q     <= map_dy[SCREEN_WIDTH-1:0];
      s1_dbg_hit_q <= s1_dbg_hit_d;
      s1_dbg_row_q <= s1_dbg_row_d;
      s1_dbg_r_q   <= s1_dbg_r_d;
      s1_dbg_c_q   <= s1_dbg_c_d;
      s1_dbg_en_q  <= debug_en;
      s1_vo_q      <= video_on;
      s1_hs_q      <= hsync_in;
      s1_vs_q      <= vsync_in;
    end
  end

  // Stage 2 debug pixel fetch: row-major bit offset into the pre-rendered rows.
  assign dbg_idx   = IW'(s1_dbg_row_q) * IW'(UNIT)
                   + (IW'(s1_dbg_r_q) * IW'(ROW_PIX) + IW'(s1_dbg_c_q)) * IW'(PIXEL_WIDTH);
  assign dbg_pix_d = debug_seq[dbg_idx +: PIXEL_WIDTH];

  // Stage 2 registers: debug pixel plus flags delayed to meet the ROM data.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dbg_pix_q    <= '0;
      s2_spr_hit_q <= '0;
      s2_map_hit_q <= 1'b0;
      s2_dbg_hit_q <= 1'b0;
      s2_dbg_en_q  <= 1'b0;
      s2_vo_q      <= 1'b0;
      s2_hs_q      <= 1'b0;
      s2_vs_q      <= 1'b0;
    end else begin
      dbg_pix_q    <= dbg_pix_d;
      s2_spr_hit_q <= s1_spr_hit_q;
      s2_map_hit_q <= s1_map_hit_q;
      s2_dbg_hit_q <= s1_dbg_hit_q;
      s2_dbg_en_q  <= s1_dbg_en_q;
      s2_vo_q      <= s1_vo_q;
      s2_hs_q      <= s1_hs_q;
      s2_vs_q      <= s1_vs_q;
    end
  end

  // Stage 3 layer priority and per-frame sprite-0 overlap accumulation.
  always_comb begin
    opaque    = '0;
    hits      = '0;
    spr_found = 1'b0;
    spr_pix   = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      opaque[i] = s2_spr_hit_q[i] && (spr_rgb[i*PIXEL_WIDTH +: PIXEL_WIDTH] != KEY_COLOR);
    end
    // Walk from the back so the lowest-index opaque sprite is left standing.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        spr_found = 1'b1;
        spr_pix   = spr_rgb[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
    for (int i = 1; i < NUM_SPRITES; i++) begin
      hits[i] = s2_vo_q && opaque[0] && opaque[i];
    end

    if (!s2_vo_q)                       rgb_d = '0;
    else if (s2_dbg_hit_q && s2_dbg_en_q) rgb_d = dbg_pix_q;
    else if (spr_found)                 rgb_d = spr_pix;
    else if (s2_map_hit_q)              rgb_d = map_rgb;
    else                                rgb_d = BG_COLOR;

    // A hit landing on the tick cycle belongs to the frame that is starting.
    if (frame_tick) begin
      collide_d = acc_q;
      acc_d     = hits;
    end else begin
      collide_d = collide_q;
      acc_d     = acc_q | hits;
    end
  end

  // Stage 3 registers: output pixel, delayed syncs, collision flags.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rgb_q     <= '0;
      vo_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      acc_q     <= '0;
      collide_q <= '0;
    end else begin
      rgb_q     <= rgb_d;
      vo_q      <= s2_vo_q;
      hs_q      <= s2_hs_q;
      vs_q      <= s2_vs_q;
      acc_q     <= acc_d;
      collide_q <= collide_d;
    end
  end

  assign spr_addr_x   = spr_ax_q;
  assign spr_addr_y   = spr_ay_q;
  assign map_addr_x   = map_ax_q;
  assign map_addr_y   = map_ay_q;
  assign rgb          = rgb_q;
  assign video_on_out = vo_q;
  assign hsync_out    = hs_q;
  assign vsync_out    = vs_q;
  assign collide      = collide_q;

endmodule
